shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 32: data width, N >= 2.
REQ-002 SHALL have parameter D_WIDTH, default $clog2(N): shift-distance width, derived from N and never overridden.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req_valid_0 / req_valid_1, input, 1 each: requester r presents an operation.
REQ-006 SHALL have ports req_ready_0 / req_ready_1, output, 1 each: the operation of requester r is accepted this cycle.
REQ-007 SHALL have ports req_x_0 / req_x_1, input, N each: operand.
REQ-008 SHALL have ports req_d_0 / req_d_1, input, D_WIDTH each: shift distance, unsigned.
REQ-009 SHALL have ports req_op_0 / req_op_1, input, 2 each: operation; 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 SHALL have port rsp_valid, output, 1: result register holds a valid result.
REQ-011 SHALL have port rsp_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port rsp_z, output, N: result.
REQ-013 SHALL have port rsp_id, output, 1: index of the requester that produced rsp_z.
REQ-014 SHALL have ports grant_cnt_0 / grant_cnt_1, output, 16 each: accepted-operation count per requester.

Function
REQ-015 SHALL use exactly one shared N-bit left-shift datapath (log2 stages) for all four operations; right shifts use bit-reverse, left shift, bit-reverse.
REQ-016 SHALL compute: SLL z = x << d; SRL z = x >> d; SRA z = x >> d with vacated MSBs filled from x[N-1]; ROL z = (x << d) | (x >> (N-d)), z = x when d = 0.
REQ-017 SHALL treat d >= N, possible when N is not a power of two, as: SLL/SRL result 0; SRA result all copies of x[N-1]; ROL rotation by d mod N.
REQ-018 SHALL define slot_free = !rsp_valid | rsp_ready.
REQ-019 SHALL grant, combinationally, at most one requester per cycle, and only when slot_free.
REQ-020 SHALL keep a 1-bit priority pointer prio: when both req_valid are high, grant requester prio; otherwise grant the single valid requester.
REQ-021 SHALL set prio to the complement of the granted index after every accepted grant; prio is unchanged when no grant occurs.
REQ-022 SHALL drive req_ready_r = slot_free & grant_r; req_ready may depend combinationally on req_valid and rsp_ready.
REQ-023 SHALL, on acceptance (req_valid_r & req_ready_r), load rsp_z with the result, rsp_id with r, and rsp_valid with 1 at the next edge; latency is 1 cycle.
REQ-024 SHALL clear rsp_valid at the edge where rsp_valid & rsp_ready and no new acceptance occurs; simultaneous consume plus accept reloads the register (throughput 1 op/cycle).
REQ-025 SHALL hold rsp_z, rsp_id and rsp_valid stable while rsp_valid & !rsp_ready.
REQ-026 SHALL increment grant_cnt_r by 1 on each acceptance by requester r, saturating at 0xFFFF.
REQ-027 SHALL not require requesters to hold inputs stable before acceptance; inputs are sampled only in the accepting cycle.

Reset
REQ-028 SHALL, when rst is high at an edge, set rsp_valid=0, rsp_z=0, rsp_id=0, prio=0, grant_cnt_0=grant_cnt_1=0.
REQ-029 SHALL drop any result held in the result register when reset is asserted, and SHALL accept no request in a cycle where rst is high (req_ready_0=req_ready_1=0).
REQ-030 SHALL accept a request in the first cycle after rst deasserts.

Verification (N=8)
REQ-031 SHALL check basic ops from requester 0 with rsp_ready=1: x=0x81,d=3,SLL -> z=0x08; x=0x90,d=2,SRL -> 0x24; x=0x90,d=2,SRA -> 0xE4; x=0x81,d=1,ROL -> 0x03; each one cycle later with rsp_id=0.
REQ-032 SHALL check that d=0 with all four ops on x=0xA5 -> z=0xA5.
REQ-033 SHALL check fairness: both requesters valid continuously after reset, rsp_ready=1 -> rsp_id sequence 0,1,0,1,...; grant counts differ by at most 1.
REQ-034 SHALL check backpressure: rsp_valid=1, rsp_ready=0 for 5 cycles -> rsp_z/rsp_id stable, both req_ready=0; after release, one result per cycle with no loss or duplication.
REQ-035 SHALL check reset mid-operation: rst pulsed while rsp_valid=1 and both requesters valid -> next cycle rsp_valid=0, counters=0, first post-reset grant goes to requester 0.
REQ-036 SHALL check counter saturation: force 65537 acceptances by requester 1 -> grant_cnt_1=0xFFFF, grant_cnt_0 unchanged.

Source files
------------

// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two requesters share one barrel-shift unit. A round-robin arbiter picks
//   at most one operation per cycle and its result lands in a single
//   output register one cycle later.
//
//   Shift operations (op): 00 SLL, 01 SRL, 10 SRA, 11 ROL.
//   All four operations go through one left-shift network of log2(N)
//   stages:
//     - Right shifts bit-reverse the operand first and bit-reverse the
//       result again afterwards.
//     - Each stage chooses which bits enter at the vacated LSB end:
//         * zeros for SLL/SRL,
//         * the sign bit for SRA,
//         * the bits just shifted out for ROL.
//       With that choice the same network also performs the rotate.
//
// Handshake:
//   A transfer happens on any edge where valid & ready are both high.
//   - A requester may change its inputs freely until it is accepted.
//   - Ready may depend combinationally on valid and on rsp_ready.
//   - The producer of a valid response holds it until it is accepted.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid_r / req_ready_r   request handshake, r = 0, 1
//   req_x_r                     N-bit operand
//   req_d_r                     D_WIDTH-bit unsigned shift distance
//   req_op_r                    2-bit operation code
//   rsp_valid / rsp_ready       result handshake
//   rsp_z                       N-bit result
//   rsp_id                      index of the requester that produced rsp_z
//   grant_cnt_r                 16-bit saturating count of acceptances
module shift_arbiter #(
  parameter int N       = 32,
  parameter int D_WIDTH = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid_0,
  input  logic               req_valid_1,
  output logic               req_ready_0,
  output logic               req_ready_1,
  input  logic [N-1:0]       req_x_0,
  input  logic [N-1:0]       req_x_1,
  input  logic [D_WIDTH-1:0] req_d_0,
  input  logic [D_WIDTH-1:0] req_d_1,
  input  logic [1:0]         req_op_0,
  input  logic [1:0]         req_op_1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [N-1:0]       rsp_z,
  output logic               rsp_id,
  output logic [15:0]        grant_cnt_0,
  output logic [15:0]        grant_cnt_1
);

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic prio;
  logic slot_free;
  logic gnt_any;
  logic gnt_id;

  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    // A cycle with reset high never accepts a request.
    gnt_any   = (req_valid_0 || req_valid_1) && slot_free && !rst;
    // On contention the pointer decides.
    // Otherwise the grant goes to whichever requester is valid.
    gnt_id    = (req_valid_0 && req_valid_1) ? prio : req_valid_1;
  end

  assign req_ready_0 = gnt_any && !gnt_id;
  assign req_ready_1 = gnt_any &&  gnt_id;

  // ---------------------------------------------------------------------
  // Operand selection and pre-reversal
  // ---------------------------------------------------------------------
  logic [N-1:0]       sel_x;
  logic [D_WIDTH-1:0] sel_d;
  logic [1:0]         sel_op;
  logic               is_right;
  logic               is_rol;
  logic               fill_bit;
  logic [N-1:0]       sh_in;

  always_comb begin
    sel_x    = gnt_id ? req_x_1  : req_x_0;
    sel_d    = gnt_id ? req_d_1  : req_d_0;
    sel_op   = gnt_id ? req_op_1 : req_op_0;
    is_right = (sel_op == OP_SRL) || (sel_op == OP_SRA);
    is_rol   = (sel_op == OP_ROL);
    fill_bit = (sel_op == OP_SRA) && sel_x[N-1];
    sh_in    = sel_x;
    if (is_right) begin
      for (int i = 0; i < N; i++) sh_in[i] = sel_x[N-1-i];
    end
  end

  // ---------------------------------------------------------------------
  // Shared left-shift network.
  // Stage k shifts by 2^k. Shift amounts of N or more push every
  // original bit out:
  //   - SLL/SRL end up all zero.
  //   - SRA ends up as copies of the sign bit.
  // For ROL, the per-stage rotations add up to d mod N on their own.
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < D_WIDTH; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [N-1:0] stg_in;
    logic [N-1:0] stg_out;
    logic [S-1:0] wrap_bits;

    if (k == 0) begin : g_first
      assign stg_in = sh_in;
    end else begin : g_next
      assign stg_in = g_stage[k-1].stg_out;
    end

    assign wrap_bits = is_rol ? stg_in[N-1 -: S] : {S{fill_bit}};
    assign stg_out   = sel_d[k] ? {stg_in[N-1-S:0], wrap_bits} : stg_in;
  end

  logic [N-1:0] sh_out;
  logic [N-1:0] result;

  assign sh_out = g_stage[D_WIDTH-1].stg_out;

  always_comb begin
    result = sh_out;
    if (is_right) begin
      for (int i = 0; i < N; i++) result[i] = sh_out[N-1-i];
    end
  end

  // ---------------------------------------------------------------------
  // Result register, priority pointer and grant counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_z       <= '0;
      rsp_id      <= 1'b0;
      prio        <= 1'b0;
      grant_cnt_0 <= '0;
      grant_cnt_1 <= '0;
    end else if (gnt_any) begin
      // A new acceptance always overwrites the register.
      // slot_free guarantees the old result is either empty or being
      // consumed on this same edge.
      rsp_valid <= 1'b1;
      rsp_z     <= result;
      rsp_id    <= gnt_id;
      prio      <= !gnt_id;
      if (!gnt_id) begin
        if (grant_cnt_0 != 16'hFFFF) grant_cnt_0 <= grant_cnt_0 + 16'd1;
      end else begin
        if (grant_cnt_1 != 16'hFFFF) grant_cnt_1 <= grant_cnt_1 + 16'd1;
      end
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter at N = 8.
//
// Reference model:
//   - exp_q mirrors the result register as a queue of {id, z}.
//   - Results are computed with plain SystemVerilog shift operators.
//   - The model also tracks the round-robin pointer and the saturating
//     grant counters.
//
// Structure:
//   - Every cycle, the outputs are compared against the model half a
//     period away from the rising edge.
//   - Directed sections cover:
//       * the basic operations,
//       * d = 0,
//       * fairness,
//       * backpressure,
//       * reset in the middle of traffic,
//       * counter saturation.
//   - Randomized traffic runs in between.
module tb_shift_arbiter;

  localparam int N  = 8;
  localparam int DW = $clog2(N);

  // ---------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // DUT signals and instance
  // ---------------------------------------------------------------------
  logic          req_valid_0, req_valid_1;
  logic          req_ready_0, req_ready_1;
  logic [N-1:0]  req_x_0, req_x_1;
  logic [DW-1:0] req_d_0, req_d_1;
  logic [1:0]    req_op_0, req_op_1;
  logic          rsp_valid, rsp_ready;
  logic [N-1:0]  rsp_z;
  logic          rsp_id;
  logic [15:0]   grant_cnt_0, grant_cnt_1;

  shift_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_x_0     (req_x_0),
    .req_x_1     (req_x_1),
    .req_d_0     (req_d_0),
    .req_d_1     (req_d_1),
    .req_op_0    (req_op_0),
    .req_op_1    (req_op_1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_z       (rsp_z),
    .rsp_id      (rsp_id),
    .grant_cnt_0 (grant_cnt_0),
    .grant_cnt_1 (grant_cnt_1)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  logic [N:0] exp_q[$];  // {id, z} of the result the register should hold
  int         m_prio;
  int         m_cnt0;
  int         m_cnt1;
  int         n_checks = 0;
  int         n_errors = 0;

  // Single comparison task: counts the check and reports a mismatch.
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result, written directly from the operation definitions.
  function automatic logic [N-1:0] ref_op(input logic [N-1:0] x, input int d,
                                         input logic [1:0] op);
    int r;
    case (op)
      2'b00: return (d >= N) ? '0 : (x << d);
      2'b01: return (d >= N) ? '0 : (x >> d);
      2'b10: return (d >= N) ? {N{x[N-1]}} : N'($signed(x) >>> d);
      default: begin
        r = d % N;
        if (r == 0) return x;
        return (x << r) | (x >> (N - r));
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // One clock cycle.
  //   1. Called just after a falling edge, with the inputs already driven.
  //   2. Compares all outputs against the model.
  //   3. Advances the model across the rising edge.
  //   4. Returns at the next falling edge.
  // ---------------------------------------------------------------------
  task automatic run_cycle();
    bit slot_free, g0, g1, both;
    #1;
    slot_free = (exp_q.size() == 0) || rsp_ready;
    both      = req_valid_0 && req_valid_1;
    g0 = !rst && slot_free && req_valid_0 && (!both || m_prio == 0);
    g1 = !rst && slot_free && req_valid_1 && (!both || m_prio == 1);

    check("req_ready_0", 32'(req_ready_0), 32'(g0));
    check("req_ready_1", 32'(req_ready_1), 32'(g1));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_z", 32'(rsp_z), 32'(exp_q[0][N-1:0]));
      check("rsp_id", 32'(rsp_id), 32'(exp_q[0][N]));
    end
    check("grant_cnt_0", 32'(grant_cnt_0), 32'(m_cnt0));
    check("grant_cnt_1", 32'(grant_cnt_1), 32'(m_cnt1));

    if (rst) begin
      exp_q.delete();
      m_prio = 0;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
      if (g0) begin
        exp_q.push_back({1'b0, ref_op(req_x_0, int'(req_d_0), req_op_0)});
        m_prio = 1;
        if (m_cnt0 < 65535) m_cnt0++;
      end else if (g1) begin
        exp_q.push_back({1'b1, ref_op(req_x_1, int'(req_d_1), req_op_1)});
        m_prio = 0;
        if (m_cnt1 < 65535) m_cnt1++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic drive_random_req(input int r);
    if (r == 0) begin
      req_x_0  = N'($urandom);
      req_d_0  = DW'($urandom);
      req_op_0 = 2'($urandom);
    end else begin
      req_x_1  = N'($urandom);
      req_d_1  = DW'($urandom);
      req_op_1 = 2'($urandom);
    end
  endtask

  // Requester 0 alone, with rsp_ready high. The result is checked
  // against a fixed constant one cycle later.
  task automatic directed_op(input string tag, input logic [N-1:0] x,
                             input int d, input logic [1:0] op,
                             input logic [N-1:0] exp_z);
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b0;
    rsp_ready   = 1'b1;
    req_x_0     = x;
    req_d_0     = DW'(d);
    req_op_0    = op;
    run_cycle();
    req_valid_0 = 1'b0;
    check(tag, 32'(rsp_z), 32'(exp_z));
    check({tag, "_id"}, 32'(rsp_id), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int saved_cnt0;
    int diff;

    rst = 1'b1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rsp_ready = 1'b0;
    req_x_0 = '0;
    req_x_1 = '0;
    req_d_0 = '0;
    req_d_1 = '0;
    req_op_0 = '0;
    req_op_1 = '0;
    exp_q.delete();
    m_prio = 0;
    m_cnt0 = 0;
    m_cnt1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then the basic operations.
    do_reset();
    directed_op("sll", 8'h81, 3, 2'b00, 8'h08);
    directed_op("srl", 8'h90, 2, 2'b01, 8'h24);
    directed_op("sra", 8'h90, 2, 2'b10, 8'hE4);
    directed_op("rol", 8'h81, 1, 2'b11, 8'h03);
    for (int op = 0; op < 4; op++) directed_op("d0", 8'hA5, 0, 2'(op), 8'hA5);
    directed_op("sra_pos", 8'h70, 7, 2'b10, 8'h00);
    directed_op("rol_max", 8'h01, 7, 2'b11, 8'h80);

    // Fairness: both requesters valid from reset onwards.
    do_reset();
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    rsp_ready   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive_random_req(0);
      drive_random_req(1);
      run_cycle();
      check("fair_id", 32'(rsp_id), 32'(k % 2));
    end
    diff = int'(grant_cnt_0) - int'(grant_cnt_1);
    check("fair_cnt", 32'((diff <= 1 && diff >= -1) ? 1 : 0), 32'd1);

    // Backpressure: hold the result for 5 cycles, then drain.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_random_req(0);
      drive_random_req(1);
      run_cycle();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_random_req(0);
      drive_random_req(1);
      run_cycle();
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    repeat (2) run_cycle();

    // Reset in the middle of traffic while a result is held.
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    rsp_ready   = 1'b0;
    run_cycle();
    run_cycle();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cnt0", 32'(grant_cnt_0), 32'd0);
    check("rst_cnt1", 32'(grant_cnt_1), 32'd0);
    rsp_ready = 1'b1;
    drive_random_req(0);
    drive_random_req(1);
    run_cycle();
    check("post_rst_id", 32'(rsp_id), 32'd0);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      rst         = ($urandom_range(0, 59) == 0);
      req_valid_0 = $urandom_range(0, 1);
      req_valid_1 = $urandom_range(0, 1);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      drive_random_req(0);
      drive_random_req(1);
      run_cycle();
    end
    rst = 1'b0;

    // Counter saturation: 65537 acceptances by requester 1 alone.
    saved_cnt0  = m_cnt0;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b1;
    rsp_ready   = 1'b1;
    for (int k = 0; k < 65537; k++) begin
      drive_random_req(1);
      run_cycle();
    end
    check("sat_cnt1", 32'(grant_cnt_1), 32'hFFFF);
    check("sat_cnt0", 32'(grant_cnt_0), 32'(saved_cnt0));
    req_valid_1 = 1'b0;
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
